// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry skid buffer that drains an async FIFO read port onto a valid/ready channel
//   rclk/rrst          read-domain clock, async active-low reset
//   rempty/rdata/rpop  FIFO read interface; rpop never depends on m_ready
//   m_valid/m_ready/m_data  output channel, data taken from the registered head entry
//   occupancy          entries held (0..2)
//   `define FIFO_RD_SKID_STALL_CNT_EN adds stall_clr/stall_cnt: saturating count of stalled cycles
module fifo_rd_skid #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rempty,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic                 rpop,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [1:0]           occupancy
`ifdef FIFO_RD_SKID_STALL_CNT_EN
  ,
  input  logic                 stall_clr,
  output logic [15:0]          stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] mem_q [2];
  logic [DATA_SIZE-1:0] mem_d [2];
  logic                 head_q, head_d, tail_q, tail_d, drain;
  // rrst gates rpop so the FIFO is never popped while the domain is held in reset
  always_comb begin
    rpop    = rrst & ~rempty & (state_q != TWO);
    m_valid = state_q != EMPTY;
    drain   = m_valid & m_ready;
    head_d  = head_q ^ drain;
    tail_d  = tail_q ^ rpop;
    mem_d   = mem_q;
    if (rpop) mem_d[tail_q] = rdata;
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = rpop ? ONE : EMPTY;
      ONE:     state_d = (rpop & ~drain) ? TWO : (~rpop & drain) ? EMPTY : ONE;
      TWO:     state_d = drain ? ONE : TWO;
      default: state_d = EMPTY;
    endcase
  end
  assign m_data    = mem_q[head_q];
  assign occupancy = state_q;
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      mem_q   <= mem_d;
    end
  end
`ifdef FIFO_RD_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = stall_clr ? 16'd0 :
                  (m_valid & ~m_ready & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) stall_cnt_q <= 16'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_rd_skid.sv
// tb_fifo_rd_skid: scoreboard bench for fifo_rd_skid with a queue model of the upstream FIFO
module tb_fifo_rd_skid;
  logic        rclk = 1'b0;
  logic        rrst = 1'b0;
  logic        rempty;
  logic [31:0] rdata;
  logic        rpop, m_valid, m_ready;
  logic [31:0] m_data;
  logic [1:0]  occupancy;
`ifdef FIFO_RD_SKID_STALL_CNT_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt;
`endif
  logic [31:0] src [$];
  logic [31:0] exp_q [$];
  int          pass = 0;
  int          total = 0;

  fifo_rd_skid #(.DATA_SIZE(32)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rpop(rpop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .occupancy(occupancy)
`ifdef FIFO_RD_SKID_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  task automatic upd();
    rempty = (src.size() == 0);
    rdata  = rempty ? 32'hxxxxxxxx : src[0];
  endtask

  // FIFO model: consume on rpop at the edge, present the next word shortly after
  always @(posedge rclk) begin
    if (rpop) void'(src.pop_front());
    #1 upd();
  end

  // Scoreboard: every handshake must deliver the next expected word
  always @(negedge rclk) begin
    if (rrst && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0)
        $display("FAIL out_unexpected: got m_data=%h, required no output", m_data);
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) $display("FAIL out_data: got %h, required %h", m_data, e);
        else pass++;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    src.push_back(w);
    exp_q.push_back(w);
    upd();
  endtask

  task automatic do_reset();
    rrst = 1'b0;
    src.delete();
    exp_q.delete();
    upd();
    tick();
    tick();
    rrst = 1'b1;
    tick();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || m_valid)
      $display("FAIL drain_timeout: left=%0d m_valid=%b, required 0/0", exp_q.size(), m_valid);
    else pass++;
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    rrst = 1'b0;
    src.delete();
    exp_q.delete();
    push(32'hA5A5A5A5);
    tick();
    tick();
    total++; if (rpop !== 1'b0) $display("FAIL rst_rpop: got %b, required 0", rpop); else pass++;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", m_valid); else pass++;
    total++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d, required 0", occupancy); else pass++;
    total++; if (m_data !== 32'd0) $display("FAIL rst_data: got %h, required 0", m_data); else pass++;
    rrst = 1'b1;
    #1;
    total++; if (rpop !== 1'b1) $display("FAIL rel_rpop: got %b, required 1", rpop); else pass++;
    tick();
    total++; if (m_valid !== 1'b1) $display("FAIL rel_valid: got %b, required 1", m_valid); else pass++;
    total++; if (m_data !== 32'hA5A5A5A5) $display("FAIL rel_data: got %h, required a5a5a5a5", m_data); else pass++;
    m_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_streaming();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(32'(i));
    tick();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (m_valid !== 1'b1 || occupancy !== 2'd1)
        $display("FAIL stream_cyc%0d: got valid=%b occ=%0d, required 1/1", i, m_valid, occupancy);
      else pass++;
      tick();
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    push(32'h10); push(32'h11); push(32'h12);
    tick(); tick(); tick();
    total++; if (occupancy !== 2'd2) $display("FAIL bp_occ: got %0d, required 2", occupancy); else pass++;
    total++; if (rpop !== 1'b0) $display("FAIL bp_rpop: got %b, required 0", rpop); else pass++;
    total++; if (m_data !== 32'h10) $display("FAIL bp_data: got %h, required 10", m_data); else pass++;
    m_ready = 1'b1;
    tick();
    total++; if (rpop !== 1'b1) $display("FAIL bp_resume: got %b, required 1", rpop); else pass++;
    wait_drain();
  endtask

  task automatic test_empty_boundary();
    m_ready = 1'b0;
    push(32'h55);
    tick(); tick(); tick();
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'h55 || occupancy !== 2'd1)
      $display("FAIL eb_hold: got valid=%b data=%h occ=%0d, required 1/55/1", m_valid, m_data, occupancy);
    else pass++;
    m_ready = 1'b1;
    tick();
    total++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL eb_empty: got valid=%b occ=%0d, required 0/0", m_valid, occupancy);
    else pass++;
    tick(); tick();
    wait_drain();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    push(32'h20); push(32'h21);
    tick(); tick(); tick();
    total++; if (occupancy !== 2'd2) $display("FAIL rm_occ: got %0d, required 2", occupancy); else pass++;
    #2 rrst = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0 || rpop !== 1'b0)
      $display("FAIL rm_async: got valid=%b occ=%0d rpop=%b, required 0/0/0", m_valid, occupancy, rpop);
    else pass++;
    src.delete();
    exp_q.delete();
    upd();
    tick();
    rrst = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (m_valid !== 1'b0) $display("FAIL rm_ghost: got valid=%b, required 0", m_valid); else pass++;
  endtask

`ifdef FIFO_RD_SKID_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    m_ready = 1'b0;
    push(32'h77);
    tick();
    for (int i = 0; i < 5; i++) tick();
    total++; if (stall_cnt !== 16'd5) $display("FAIL sc_five: got %0d, required 5", stall_cnt); else pass++;
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    total++; if (stall_cnt !== 16'd0) $display("FAIL sc_clr: got %0d, required 0", stall_cnt); else pass++;
    for (int i = 0; i < 65535; i++) tick();
    total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sc_max: got %h, required ffff", stall_cnt); else pass++;
    tick(); tick(); tick();
    total++; if (stall_cnt !== 16'hFFFF) $display("FAIL sc_sat: got %h, required ffff", stall_cnt); else pass++;
    m_ready = 1'b1;
    wait_drain();
  endtask
`endif

  initial begin
    m_ready = 1'b0;
    upd();
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_reset_mid();
`ifdef FIFO_RD_SKID_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
